// File: rtl/btn_conditioner.sv
// Per-channel button front end: 2-flop synchroniser, edge debounce, and a
// press/hold/repeat FSM producing a registered level plus single-cycle event pulses.
module btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DB_DOWN = 3'd1;
  localparam logic [2:0] ST_PRESSED = 3'd2;
  localparam logic [2:0] ST_REPEAT  = 3'd3;
  localparam logic [2:0] ST_DB_UP   = 3'd4;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic          s1;
    logic          sync;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          repeat_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1   <= 1'b0;
        sync <= 1'b0;
      end else begin
        s1   <= btn_raw[i];
        sync <= s1;
      end
    end

    // The sync level is tested before the terminal count, so a bounce on the
    // final counting cycle always wins over the pending event.
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (sync) begin
              state <= ST_DB_DOWN;
              cnt   <= '0;
            end
          end
          ST_DB_DOWN: begin
            if (!sync) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state   <= ST_PRESSED;
              cnt     <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_PRESSED: begin
            if (!sync) begin
              state <= ST_DB_UP;
              cnt   <= '0;
            end else if (cnt == HOLD_LAST) begin
              state    <= ST_REPEAT;
              cnt      <= '0;
              repeat_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_REPEAT: begin
            if (!sync) begin
              state <= ST_DB_UP;
              cnt   <= '0;
            end else if (cnt == REP_LAST) begin
              cnt      <= '0;
              repeat_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_DB_UP: begin
            // A glitch back to pressed restarts the hold timer without a new press pulse.
            if (sync) begin
              state <= ST_PRESSED;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state     <= ST_IDLE;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing parameters; per-edge
// expectations come from a hand-built vector table plus a latency sequence.
module tb_btn_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int HC = 10;
  localparam int RC = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;

  int checks   = 0;
  int failures = 0;

  // Each record holds its inputs for n edges; the outputs must equal the
  // expected bundle after every one of those edges.
  typedef struct {
    logic       rst;
    logic [1:0] raw;
    int         n;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] rpt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  task automatic add_vec(input logic r, input logic [1:0] raw, input int n,
                         input logic [1:0] lvl, input logic [1:0] prs,
                         input logic [1:0] rel, input logic [1:0] rpt);
    vec_t v;
    v.rst = r; v.raw = raw; v.n = n;
    v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: lvl/prs/rel/rpt got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    rst     = v.rst;
    btn_raw = v.raw;
    for (int k = 0; k < v.n; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_edge%0d", idx, k + 1),
                   {btn_level, btn_press, btn_release, btn_repeat},
                   {v.lvl, v.prs, v.rel, v.rpt});
    end
  endtask

  // Drives raw and counts edges until the selected pulse on channel ch; -1 on timeout.
  task automatic wait_pulse(input logic [1:0] raw_val, input int ch, input bit want_release,
                            output int edges);
    bit seen;
    btn_raw = raw_val;
    edges   = -1;
    seen    = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (want_release ? btn_release[ch] : btn_press[ch]) begin
        edges = k;
        seen  = 1'b1;
      end
    end
  endtask

  initial begin
    int lat;
    rst     = 1'b1;
    btn_raw = 2'b00;

    // reset state, clean press, long hold repeats, release
    add_vec(1, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 6, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b01, 9, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b01, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b01, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b01, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b00, 6, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    // bounce rejected on the way down
    add_vec(0, 2'b01, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 8, 2'b00, 2'b00, 2'b00, 2'b00);
    // parallel channels, then ch1 released alone, ch0 keeps repeating
    add_vec(0, 2'b11, 6, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b00);
    add_vec(0, 2'b11, 2, 2'b11, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 6, 2'b11, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b10, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b00, 6, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    // release glitch restarts hold; later release lands on a repeat terminal cycle
    add_vec(0, 2'b01, 6, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b01, 3, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 12, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 6, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    // reset during debounce and during repeat, button held through reset
    add_vec(0, 2'b01, 4, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(1, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 6, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b01, 9, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add_vec(0, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(1, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 6, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b00, 6, 2'b01, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00);

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // ch1 press and release latency measured edge by edge
    rst = 1'b0;
    wait_pulse(2'b10, 1, 1'b0, lat);
    check_int("ch1_press_latency", lat, DB + 3);
    @(posedge clk);
    #1;
    check_output("ch1_press_single_cycle",
                 {btn_level, btn_press, btn_release, btn_repeat},
                 {2'b10, 2'b00, 2'b00, 2'b00});
    wait_pulse(2'b00, 1, 1'b1, lat);
    check_int("ch1_release_latency", lat, DB + 3);
    check_int("ch1_level_after_release", int'(btn_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
